// File: rtl/aes_dec_pkg.sv
// Shared sizes and FSM state type for the AES-128 decrypt scheduler.
package aes_dec_pkg;

    localparam int unsigned NUM_RKEYS = 11;
    localparam int unsigned RKEY_AW   = 4;
    localparam int unsigned BLK_W     = 128;

    localparam logic [RKEY_AW-1:0] MAX_RKEY = RKEY_AW'(NUM_RKEYS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StResp} state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time is granted.
module rr_arb2 (
    input  logic       last_grant_i,
    input  logic [1:0] valid_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        unique case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/aes_dec_scheduler.sv
// Shares one AES-128 decrypt core between two requesters and owns the round-key table.
// Optional watchdog on the core is enabled by defining AES_DEC_TIMEOUT_EN.
module aes_dec_scheduler
  import aes_dec_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req0_valid_i,
  output logic               req0_ready_o,
  input  logic [BLK_W-1:0]   req0_data_i,
  input  logic               req1_valid_i,
  output logic               req1_ready_o,
  input  logic [BLK_W-1:0]   req1_data_i,
  input  logic               key_we_i,
  input  logic [RKEY_AW-1:0] key_addr_i,
  input  logic [BLK_W-1:0]   key_wdata_i,
  output logic               key_wr_err_o,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [BLK_W-1:0]   rsp_data_o,
  output logic               rsp_id_o,
  output logic               rsp_err_o,
  output logic               busy_o,
  output logic               core_en_o,
  output logic [BLK_W-1:0]   core_cipher_o,
  input  logic [RKEY_AW-1:0] core_round_i,
  output logic [BLK_W-1:0]   core_round_key_o,
  input  logic [BLK_W-1:0]   core_plain_i,
  input  logic               core_dn_i
);

  state_e           state_q;
  logic             last_grant_q;
  logic             core_en_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic             key_wr_err_q;
  logic [BLK_W-1:0] cipher_q;
  logic [BLK_W-1:0] rsp_data_q;
  logic [BLK_W-1:0] key_mem_q [NUM_RKEYS];

  logic [1:0]       arb_valid;
  logic [1:0]       grant;
  logic             key_ok;

  assign arb_valid = (state_q == StIdle) ? {req1_valid_i, req0_valid_i} : 2'b00;

  rr_arb2 u_arb (
    .last_grant_i (last_grant_q),
    .valid_i      (arb_valid),
    .grant_o      (grant)
  );

  assign req0_ready_o  = grant[0];
  assign req1_ready_o  = grant[1];
  assign busy_o        = (state_q != StIdle);
  assign core_en_o     = core_en_q;
  assign core_cipher_o = cipher_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_id_o      = rsp_id_q;
  assign key_wr_err_o  = key_wr_err_q;

  // Keys are only read from RUN onwards, so a write in the grant cycle is safe.
  assign key_ok = key_we_i && (state_q == StIdle) && (key_addr_i <= MAX_RKEY);

  // An unknown round index fails the compare and leaves the zero default in place.
  always_comb begin
    core_round_key_o = '0;
    if (core_round_i <= MAX_RKEY) begin
      core_round_key_o = key_mem_q[core_round_i];
    end
  end

`ifdef AES_DEC_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;
  logic       rsp_err_q;
  logic       tmo_hit;

  assign tmo_hit   = (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign rsp_err_o = rsp_err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      core_en_q    <= 1'b0;
      cipher_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
      key_wr_err_q <= 1'b0;
      for (int i = 0; i < NUM_RKEYS; i++) begin
        key_mem_q[i] <= '0;
      end
`ifdef AES_DEC_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      key_wr_err_q <= key_we_i && !key_ok;
      if (key_ok) begin
        key_mem_q[key_addr_i] <= key_wdata_i;
      end
      unique case (state_q)
        StIdle: begin
          if (grant != 2'b00) begin
            cipher_q     <= grant[1] ? req1_data_i : req0_data_i;
            rsp_id_q     <= grant[1];
            last_grant_q <= grant[1];
            core_en_q    <= 1'b1;
            state_q      <= StRun;
`ifdef AES_DEC_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            rsp_err_q    <= 1'b0;
`endif
          end
        end
        StRun: begin
          if (core_dn_i) begin
            rsp_data_q <= core_plain_i;
            core_en_q  <= 1'b0;
            state_q    <= StDrain;
`ifdef AES_DEC_TIMEOUT_EN
          end else if (tmo_hit) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
            core_en_q  <= 1'b0;
            state_q    <= StDrain;
          end else begin
            tmo_cnt_q  <= tmo_cnt_q + 8'd1;
`endif
          end
        end
        // One idle cycle with core_en low lets the core drop its done flag.
        StDrain: begin
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dec_scheduler.sv
// Bench for aes_dec_scheduler: behavioural AES-128 inverse-cipher core stub plus a response scoreboard.
module tb_aes_dec_scheduler;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [127:0] req0_data = '0, req1_data = '0;
  logic         key_we = 1'b0;
  logic [3:0]   key_addr = '0;
  logic [127:0] key_wdata = '0;
  logic         key_wr_err;
  logic         rsp_valid, rsp_ready = 1'b0;
  logic [127:0] rsp_data;
  logic         rsp_id, rsp_err, busy, core_en;
  logic [127:0] core_cipher, core_round_key;
  logic [3:0]   core_round;
  logic [127:0] core_plain = '0;
  logic         core_dn = 1'b0;

  logic         ovr_en = 1'b0;
  logic [3:0]   ovr_round = '0;
  logic         stub_mute = 1'b0;

  int unsigned  vectors = 0;
  int unsigned  miscompares = 0;

  typedef struct {
    logic         id;
    logic [127:0] data;
    logic         err;
  } exp_t;
  exp_t         sb[$];
  exp_t         mon_e;

  logic [7:0]   inv_sbox [256];
  logic [127:0] fips_rk [11];
  logic         tb_last = 1'b1;

  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam int TMO = 32;

  always #5 clk = ~clk;

  aes_dec_scheduler #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req0_valid_i     (req0_valid),
    .req0_ready_o     (req0_ready),
    .req0_data_i      (req0_data),
    .req1_valid_i     (req1_valid),
    .req1_ready_o     (req1_ready),
    .req1_data_i      (req1_data),
    .key_we_i         (key_we),
    .key_addr_i       (key_addr),
    .key_wdata_i      (key_wdata),
    .key_wr_err_o     (key_wr_err),
    .rsp_valid_o      (rsp_valid),
    .rsp_ready_i      (rsp_ready),
    .rsp_data_o       (rsp_data),
    .rsp_id_o         (rsp_id),
    .rsp_err_o        (rsp_err),
    .busy_o           (busy),
    .core_en_o        (core_en),
    .core_cipher_o    (core_cipher),
    .core_round_i     (core_round),
    .core_round_key_o (core_round_key),
    .core_plain_i     (core_plain),
    .core_dn_i        (core_dn)
  );

  // ---------------- AES helpers ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] w;
    w = {v, v} << n;
    return w[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] b, inv, s;
    for (int x = 0; x < 256; x++) begin
      b = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(b, 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      inv_sbox[s] = b;
    end
  endtask

  // InvShiftRows, InvSubBytes, AddRoundKey and optionally InvMixColumns.
  function automatic logic [127:0] inv_round(input logic [127:0] st, input logic [127:0] rk,
                                             input logic mix);
    logic [7:0]   a [16];
    logic [7:0]   t [16];
    logic [7:0]   m [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = st[127-8*i -: 8];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[r+4*c] = inv_sbox[a[r + 4*((c - r + 4) % 4)]] ^ rk[127-8*(r+4*c) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      m[4*c]   = gmul(t[4*c], 8'h0e) ^ gmul(t[4*c+1], 8'h0b) ^ gmul(t[4*c+2], 8'h0d)
               ^ gmul(t[4*c+3], 8'h09);
      m[4*c+1] = gmul(t[4*c], 8'h09) ^ gmul(t[4*c+1], 8'h0e) ^ gmul(t[4*c+2], 8'h0b)
               ^ gmul(t[4*c+3], 8'h0d);
      m[4*c+2] = gmul(t[4*c], 8'h0d) ^ gmul(t[4*c+1], 8'h09) ^ gmul(t[4*c+2], 8'h0e)
               ^ gmul(t[4*c+3], 8'h0b);
      m[4*c+3] = gmul(t[4*c], 8'h0b) ^ gmul(t[4*c+1], 8'h0d) ^ gmul(t[4*c+2], 8'h09)
               ^ gmul(t[4*c+3], 8'h0e);
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = mix ? m[i] : t[i];
    return o;
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] ct);
    logic [127:0] st;
    st = ct ^ fips_rk[10];
    for (int r = 9; r >= 1; r--) st = inv_round(st, fips_rk[r], 1'b1);
    return inv_round(st, fips_rk[0], 1'b0);
  endfunction

  // ---------------- core stub: one round per cycle, keys fetched via core_round_key -------------
  typedef enum logic [1:0] {CIdle, CRun, CDone} cph_e;
  cph_e         cph = CIdle;
  logic [3:0]   cround = 4'd0;
  logic [127:0] cst = '0;

  assign core_round = ovr_en ? ovr_round : ((cph == CRun) ? cround : 4'd15);

  always @(posedge clk) begin
    if (!core_en) begin
      cph     <= CIdle;
      core_dn <= 1'b0;
    end else begin
      case (cph)
        CIdle: begin
          cst    <= core_cipher;
          cround <= 4'd10;
          cph    <= CRun;
        end
        CRun: begin
          if (cround == 4'd10) cst <= cst ^ core_round_key;
          else cst <= inv_round(cst, core_round_key, cround != 4'd0);
          if (cround == 4'd0) begin
            core_plain <= inv_round(cst, core_round_key, 1'b0);
            core_dn    <= !stub_mute;
            cph        <= CDone;
          end
          cround <= cround - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- checking ----------------
  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      chk1("rsp_expected", sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chkw("rsp_data", rsp_data, mon_e.data);
        chk1("rsp_id", rsp_id, mon_e.id);
        chk1("rsp_err", rsp_err, mon_e.err);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_key(input logic [3:0] a, input logic [127:0] d);
    key_we = 1'b1;
    key_addr = a;
    key_wdata = d;
    step();
    key_we = 1'b0;
  endtask

  task automatic load_keys();
    for (int i = 0; i < 11; i++) wr_key(4'(i), fips_rk[i]);
  endtask

  task automatic send(input logic id, input logic [127:0] d, input logic [127:0] ed,
                      input logic ee);
    int n;
    n = 0;
    if (id) begin
      req1_valid = 1'b1;
      req1_data  = d;
    end else begin
      req0_valid = 1'b1;
      req0_data  = d;
    end
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 40) begin
      step();
      n++;
    end
    chk1("grant_seen", n < 40, 1'b1);
    sb.push_back('{id: id, data: ed, err: ee});
    tb_last = id;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Called one cycle after the handshake edge; n counts cycles from that edge.
  task automatic wait_rsp(input int max, output int n);
    n = 1;
    while (!rsp_valid && n <= max) begin
      step();
      n++;
    end
    chk1("rsp_within_bound", n <= max, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           n;
    int           ng;
    int           i0, i1;
    logic         g;
    logic         seen;
    logic [127:0] d0 [4];
    logic [127:0] d1 [4];
    logic [127:0] ct, pt;

    build_sbox();
    fips_rk = '{128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
                128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
                128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
                128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
                128'h13111d7fe3944a17f307a78b4d2b30c5};

    // Reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_core_en", core_en, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk1("rst_key_wr_err", key_wr_err, 1'b0);
    chkw("rst_rsp_data", rsp_data, '0);
    chk1("rst_rsp_id", rsp_id, 1'b0);
    ovr_en = 1'b1;
    ovr_round = 4'd7;
    #1;
    chkw("rst_key_mem", core_round_key, '0);
    ovr_en = 1'b0;

    // Key load and table read-out, including out-of-range indices
    for (int i = 0; i < 11; i++) begin
      wr_key(4'(i), fips_rk[i]);
      chk1("key_wr_accept", key_wr_err, 1'b0);
    end
    ovr_en = 1'b1;
    for (int r = 0; r < 16; r += 3) begin
      ovr_round = 4'(r);
      #1;
      chkw("round_key_lookup", core_round_key, (r <= 10) ? fips_rk[r] : 128'h0);
    end
    ovr_round = 4'd11;
    #1;
    chkw("round_key_11", core_round_key, '0);
    ovr_en = 1'b0;

    // 1: FIPS-197 known answer on req0 with latency bound
    rsp_ready = 1'b1;
    send(1'b0, FIPS_CT, FIPS_PT, 1'b0);
    chk1("run_core_en", core_en, 1'b1);
    chk1("run_busy", busy, 1'b1);
    chkw("run_core_cipher", core_cipher, FIPS_CT);
    wait_rsp(18, n);
    step();
    chk1("idle_after_rsp", busy, 1'b0);

    // 3: key writes while RUN and to index 11 are rejected
    ct = {$urandom, $urandom, $urandom, $urandom};
    send(1'b1, ct, model_dec(ct), 1'b0);
    step();
    wr_key(4'd3, ~fips_rk[3]);
    chk1("key_wr_err_run", key_wr_err, 1'b1);
    step();
    chk1("key_wr_err_pulse", key_wr_err, 1'b0);
    wait_rsp(18, n);
    step();
    wr_key(4'd11, 128'hdead_beef);
    chk1("key_wr_err_addr11", key_wr_err, 1'b1);
    ovr_en = 1'b1;
    ovr_round = 4'd3;
    #1;
    chkw("key3_unchanged", core_round_key, fips_rk[3]);
    ovr_round = 4'd11;
    #1;
    chkw("key11_not_stored", core_round_key, '0);
    ovr_en = 1'b0;
    step();
    chk1("key_wr_err_clear", key_wr_err, 1'b0);

    // 2: both requesters valid, four each, strict alternation
    for (int k = 0; k < 4; k++) begin
      d0[k] = {$urandom, $urandom, $urandom, $urandom};
      d1[k] = {$urandom, $urandom, $urandom, $urandom};
    end
    ng = 0;
    i0 = 0;
    i1 = 0;
    req0_valid = 1'b1;
    req0_data  = d0[0];
    req1_valid = 1'b1;
    req1_data  = d1[0];
    for (int cyc = 0; cyc < 400 && ng < 8; cyc++) begin
      #1;
      if (req0_ready || req1_ready) begin
        chk1("grant_onehot", req0_ready && req1_ready, 1'b0);
        chk1("grant_rr", req1_ready,
             (req0_valid && req1_valid) ? !tb_last : req1_valid);
        chk1("grant_order", req1_ready, (ng % 2) == 1);
        g = req1_ready;
        sb.push_back('{id: g, data: model_dec(g ? d1[i1] : d0[i0]), err: 1'b0});
        tb_last = g;
        step();
        if (g) begin
          i1++;
          if (i1 < 4) req1_data = d1[i1];
          else req1_valid = 1'b0;
        end else begin
          i0++;
          if (i0 < 4) req0_data = d0[i0];
          else req0_valid = 1'b0;
        end
        ng++;
      end else begin
        step();
      end
    end
    chk1("all_grants", ng == 8, 1'b1);
    wait_rsp(18, n);
    step();

    // 4: back-pressure holds the response and blocks new grants
    rsp_ready = 1'b0;
    ct = {$urandom, $urandom, $urandom, $urandom};
    pt = model_dec(ct);
    send(1'b0, ct, pt, 1'b0);
    wait_rsp(18, n);
    req1_valid = 1'b1;
    req1_data  = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 20; k++) begin
      chk1("hold_rsp_valid", rsp_valid, 1'b1);
      chkw("hold_rsp_data", rsp_data, pt);
      chk1("hold_rsp_id", rsp_id, 1'b0);
      chk1("hold_no_grant", req1_ready, 1'b0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk1("grant_after_rsp", req1_ready, 1'b1);
    req1_valid = 1'b0;
    step();
    chk1("withdraw_idle", busy, 1'b0);

    // 5: reset in RUN drops the transaction
    ct = {$urandom, $urandom, $urandom, $urandom};
    send(1'b0, ct, model_dec(ct), 1'b0);
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    tb_last = 1'b1;
    chk1("rst_run_core_en", core_en, 1'b0);
    chk1("rst_run_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_run_busy", busy, 1'b0);
    ovr_en = 1'b1;
    ovr_round = 4'd10;
    #1;
    chkw("rst_run_key_mem", core_round_key, '0);
    ovr_en = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      seen = seen | rsp_valid;
      step();
    end
    chk1("no_rsp_after_rst", seen, 1'b0);

    // After reset req0 wins the first tie
    load_keys();
    req0_valid = 1'b1;
    req0_data  = FIPS_CT;
    req1_valid = 1'b1;
    req1_data  = {$urandom, $urandom, $urandom, $urandom};
    #1;
    chk1("first_tie_req0", req0_ready, 1'b1);
    chk1("first_tie_not_req1", req1_ready, 1'b0);
    sb.push_back('{id: 1'b0, data: FIPS_PT, err: 1'b0});
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(18, n);
    step();

`ifdef AES_DEC_TIMEOUT_EN
    // 6: silent core triggers the watchdog
    stub_mute = 1'b1;
    send(1'b1, {$urandom, $urandom, $urandom, $urandom}, '0, 1'b1);
    wait_rsp(TMO + 2, n);
    step();
    stub_mute = 1'b0;
`endif

    step();
    chk1("scoreboard_drained", sb.size() == 0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
